// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - signal bundle between the UART RX sequencer and its datapath helpers
//
// Ports carried (slave = uart_rx_ctrl side):
//   rx_in        serial receive line, idle high
//   prescale     oversampling ratio (8, 16 or 32)
//   par_en       frame carries a parity bit
//   strt_glitch  start checker result (registered)
//   par_err      parity checker result (registered)
//   stp_err      stop checker result (registered)
//   edge_cnt     oversample edge index within the current bit
//   bit_cnt      data bit index within the data phase
//   dat_samp_en  bit sampler enable
//   strt_chk_en  start checker enable
//   par_chk_en   parity checker enable
//   stp_chk_en   stop checker enable
//   deser_en     one-cycle shift strobe to the deserializer
//   data_valid   one-cycle pulse, frame good
//   frame_err    one-cycle pulse, parity or stop error
//   busy         sequencer not idle
interface uart_rx_ctrl_if #(
  parameter int PRESCALE_W = 6
);
  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  dat_samp_en;
  logic                  strt_chk_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  deser_en;
  logic                  data_valid;
  logic                  frame_err;
  logic                  busy;

  modport master (
    output rx_in, prescale, par_en, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en,
           stp_chk_en, deser_en, data_valid, frame_err, busy
  );

  modport slave (
    input  rx_in, prescale, par_en, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en,
           stp_chk_en, deser_en, data_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - receive frame sequencer for the UART RX path
//
// Ports:
//   clk  oversampling clock
//   rst  asynchronous active-low reset
//   bus  uart_rx_ctrl_if.slave: line/config/checker results in,
//        counters, checker enables, deserializer strobe and frame pulses out
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    CHECK  = 3'd5
  } state_t;

  localparam logic [PRESCALE_W-1:0] ONE  = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] PS8  = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] PS16 = PRESCALE_W'(16);
  localparam logic [PRESCALE_W-1:0] PS32 = PRESCALE_W'(32);
  localparam logic [3:0]            LAST_BIT = 4'(DATA_WIDTH - 1);

  state_t                state, state_nx;
  logic [PRESCALE_W-1:0] edge_q, edge_nx;
  logic [3:0]            bit_q, bit_nx;
  logic [PRESCALE_W-1:0] prescale_q, prescale_sel, last_edge;
  logic                  par_en_q, par_err_q;
  logic                  in_bit, end_of_bit;
  logic                  strt_chk_en, par_chk_en, stp_chk_en;
  logic                  deser_en, data_valid, frame_err;

  // Unsupported ratios fall back to 8 so the edge counter always wraps.
  always_comb begin
    prescale_sel = PS8;
    if (bus.prescale == PS16 || bus.prescale == PS32)
      prescale_sel = bus.prescale;
  end

  assign last_edge  = prescale_q - ONE;
  assign in_bit     = (state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP);
  assign end_of_bit = in_bit && (edge_q == last_edge);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      edge_q <= edge_nx;
      bit_q  <= bit_nx;
      // Config is frozen for the whole frame at start detection.
      if (state == IDLE && !bus.rx_in) begin
        prescale_q <= prescale_sel;
        par_en_q   <= bus.par_en;
      end
      // Parity result is only meaningful on the first stop-bit cycle;
      // holding it lets CHECK combine it with the later stop result.
      if (state == STOP && edge_q == '0)
        par_err_q <= bus.par_err & par_en_q;
    end
  end

  always_comb begin
    state_nx    = state;
    edge_nx     = '0;
    bit_nx      = bit_q;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    deser_en    = 1'b0;
    data_valid  = 1'b0;
    frame_err   = 1'b0;

    if (in_bit)
      edge_nx = end_of_bit ? '0 : edge_q + ONE;

    case (state)
      IDLE: begin
        bit_nx = '0;
        if (!bus.rx_in)
          state_nx = START;
      end
      START: begin
        strt_chk_en = 1'b1;
        if (end_of_bit) begin
          state_nx = DATA;
          bit_nx   = '0;
        end
      end
      DATA: begin
        // The start checker verdict is ready on the first data cycle;
        // a glitch drops the frame without any pulse.
        if (bit_q == '0 && edge_q == '0 && bus.strt_glitch) begin
          state_nx = IDLE;
          edge_nx  = '0;
        end else if (end_of_bit) begin
          deser_en = 1'b1;
          if (bit_q == LAST_BIT) begin
            bit_nx   = '0;
            state_nx = par_en_q ? PARITY : STOP;
          end else begin
            bit_nx = bit_q + 4'd1;
          end
        end
      end
      PARITY: begin
        par_chk_en = 1'b1;
        if (end_of_bit)
          state_nx = STOP;
      end
      STOP: begin
        stp_chk_en = 1'b1;
        if (end_of_bit)
          state_nx = CHECK;
      end
      CHECK: begin
        if (par_err_q || bus.stp_err)
          frame_err = 1'b1;
        else
          data_valid = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.edge_cnt    = edge_q;
  assign bus.bit_cnt     = bit_q;
  assign bus.dat_samp_en = in_bit;
  assign bus.strt_chk_en = strt_chk_en;
  assign bus.par_chk_en  = par_chk_en;
  assign bus.stp_chk_en  = stp_chk_en;
  assign bus.deser_en    = deser_en;
  assign bus.data_valid  = data_valid;
  assign bus.frame_err   = frame_err;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
  localparam int PW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.PRESCALE_W(PW)) bus ();

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // per-frame observations
  int         valid_at, ferr_at, n_valid, n_ferr, n_deser, bad_edge;
  int         n_par, busy_low_at, n_both;
  logic [7:0] shreg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic rx_bit(input int n, input int p, input bit pe, input logic [7:0] d);
    int s;
    if (n < 1) return 1'b0;
    s = (n - 1) / p;
    if (s == 0) return 1'b0;
    if (s <= 8) return d[s-1];
    if (s == 9 && pe) return ^d;
    return 1'b1;
  endfunction

  // Interval 0 holds rx_in low in IDLE; interval n is the n-th clock after that.
  task automatic frame(input int ps, input int p, input bit pe, input logic [7:0] d,
                       input bit glitch, input bit perr, input bit serr, input int chg_at);
    int lat;
    lat = 1 + p * (10 + (pe ? 1 : 0));
    valid_at = 0; ferr_at = 0; n_valid = 0; n_ferr = 0; n_deser = 0;
    bad_edge = 0; n_par = 0; busy_low_at = 0; n_both = 0; shreg = '0;
    bus.prescale = PW'(ps);
    bus.par_en   = pe;
    @(posedge clk); #1;
    bus.rx_in = 1'b0;
    for (int n = 1; n <= lat + 3; n++) begin
      @(posedge clk); #1;
      bus.rx_in       = glitch ? (n < 3 ? 1'b0 : 1'b1) : rx_bit(n, p, pe, d);
      bus.strt_glitch = glitch && (n == p + 1);
      bus.par_err     = perr && (n == lat - p);
      bus.stp_err     = serr && (n == lat);
      if (chg_at != 0 && n == chg_at) begin
        bus.prescale = PW'(16);
        bus.par_en   = 1'b1;
      end
      @(negedge clk);
      if (bus.deser_en) begin
        n_deser++;
        if (int'(bus.edge_cnt) != p - 1) bad_edge++;
        shreg = {bus.rx_in, shreg[7:1]};
      end
      if (bus.data_valid) begin n_valid++; valid_at = n; end
      if (bus.frame_err)  begin n_ferr++;  ferr_at  = n; end
      if (bus.data_valid && bus.frame_err) n_both++;
      if (bus.par_chk_en) n_par++;
      if (!bus.busy && busy_low_at == 0) busy_low_at = n;
    end
    bus.strt_glitch = 1'b0;
    bus.par_err     = 1'b0;
    bus.stp_err     = 1'b0;
    bus.rx_in       = 1'b1;
  endtask

  task automatic expect_frame(input string t, input int v_at, input int f_at, input int deser,
                              input int par, input logic [7:0] d, input int idle_at);
    chk({t, " valid_at"}, valid_at, v_at);
    chk({t, " ferr_at"}, ferr_at, f_at);
    chk({t, " n_valid"}, n_valid, (v_at != 0) ? 1 : 0);
    chk({t, " n_ferr"}, n_ferr, (f_at != 0) ? 1 : 0);
    chk({t, " n_deser"}, n_deser, deser);
    chk({t, " deser_edge"}, bad_edge, 0);
    if (deser == 8) chk({t, " data"}, shreg, d);
    chk({t, " par_cycles"}, n_par, par);
    chk({t, " both"}, n_both, 0);
    chk({t, " idle_at"}, busy_low_at, idle_at);
  endtask

  initial begin
    rst             = 1'b0;
    bus.rx_in       = 1'b1;
    bus.prescale    = PW'(8);
    bus.par_en      = 1'b0;
    bus.strt_glitch = 1'b0;
    bus.par_err     = 1'b0;
    bus.stp_err     = 1'b0;
    #3;
    chk("rst busy", bus.busy, 0);
    chk("rst edge_cnt", bus.edge_cnt, 0);
    chk("rst bit_cnt", bus.bit_cnt, 0);
    chk("rst outs", {bus.dat_samp_en, bus.strt_chk_en, bus.par_chk_en, bus.stp_chk_en,
                     bus.deser_en, bus.data_valid, bus.frame_err}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // 1: prescale 8, no parity
    frame(8, 8, 0, 8'h55, 0, 0, 0, 0);
    expect_frame("t1", 81, 0, 8, 0, 8'h55, 82);

    // 2: prescale 16 with good parity
    frame(16, 16, 1, 8'hA3, 0, 0, 0, 0);
    expect_frame("t2", 177, 0, 8, 16, 8'hA3, 178);

    // 3: start glitch aborts silently
    frame(8, 8, 0, 8'h00, 1, 0, 0, 0);
    expect_frame("t3", 0, 0, 0, 0, 8'h00, 10);

    // 4: parity error, then stop error
    frame(8, 8, 1, 8'h3C, 0, 1, 0, 0);
    expect_frame("t4p", 0, 89, 8, 8, 8'h3C, 90);
    frame(8, 8, 0, 8'hC3, 0, 0, 1, 0);
    expect_frame("t4s", 0, 81, 8, 0, 8'hC3, 82);

    // 5: reset mid-DATA at bit 4
    bus.prescale = PW'(8);
    bus.par_en   = 1'b0;
    @(posedge clk); #1;
    bus.rx_in = 1'b0;
    for (int n = 1; n <= 44; n++) begin
      @(posedge clk); #1;
      bus.rx_in = rx_bit(n, 8, 0, 8'hFF);
    end
    @(negedge clk);
    chk("t5 pre bit_cnt", bus.bit_cnt, 4);
    chk("t5 pre busy", bus.busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5 busy", bus.busy, 0);
    chk("t5 edge_cnt", bus.edge_cnt, 0);
    chk("t5 bit_cnt", bus.bit_cnt, 0);
    chk("t5 outs", {bus.dat_samp_en, bus.strt_chk_en, bus.par_chk_en, bus.stp_chk_en,
                    bus.deser_en, bus.data_valid, bus.frame_err}, 0);
    bus.rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    frame(8, 8, 0, 8'h96, 0, 0, 0, 0);
    expect_frame("t5", 81, 0, 8, 0, 8'h96, 82);

    // 6: mid-frame config change ignored, then applied, then illegal prescale
    frame(8, 8, 0, 8'h5A, 0, 0, 0, 30);
    expect_frame("t6a", 81, 0, 8, 0, 8'h5A, 82);
    frame(16, 16, 1, 8'h3C, 0, 0, 0, 0);
    expect_frame("t6b", 177, 0, 8, 16, 8'h3C, 178);
    frame(5, 8, 0, 8'hE1, 0, 0, 0, 0);
    expect_frame("t6c", 81, 0, 8, 0, 8'hE1, 82);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
